// File: rtl/cpx_io_rcv_q_if.sv
// Bundles the IO request/data inputs and the CPX output/grant/error signals of the receive queue.
interface cpx_io_rcv_q_if #(
    parameter int DW = 145,
    parameter int ND = 8
);
    logic [ND-1:0] io_cpx_req_cq2;
    logic [DW-1:0] io_cpx_data_ca2;
    logic [ND-1:0] cpx_out_rdy;
    logic [ND-1:0] cpx_out_vld;
    logic [DW-1:0] cpx_out_data;
    logic [ND-1:0] cpx_io_grant_cx;
    logic [1:0]    cpx_io_err;

    modport slave (
        input  io_cpx_req_cq2, io_cpx_data_ca2, cpx_out_rdy,
        output cpx_out_vld, cpx_out_data, cpx_io_grant_cx, cpx_io_err
    );

    modport master (
        output io_cpx_req_cq2, io_cpx_data_ca2, cpx_out_rdy,
        input  cpx_out_vld, cpx_out_data, cpx_io_grant_cx, cpx_io_err
    );
endinterface

// File: rtl/cpx_io_rcv_q.sv
// CPX-side receive queue: 2-entry FIFO per destination CPU, round-robin drain onto one
// output port, and a registered per-destination grant returned to the IO source as credit.
module cpx_io_rcv_q #(
    parameter int DW = 145,
    parameter int ND = 8
) (
    input  logic          rclk,
    input  logic          rst_l,
    cpx_io_rcv_q_if.slave bus
);
    localparam int RW = (ND > 1) ? $clog2(ND) : 1;
    typedef logic [RW-1:0] idx_t;

    function automatic logic is_onehot(input logic [ND-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < ND; i++) begin
            n = v[i] ? n + 1 : n;
        end
        return (n == 1);
    endfunction

    function automatic idx_t onehot_idx(input logic [ND-1:0] v);
        idx_t r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r = v[i] ? idx_t'(i) : r;
        end
        return r;
    endfunction

    logic [DW-1:0] mem_q [ND][2];
    logic [DW-1:0] mem_d [ND][2];
    logic [1:0]    cnt_q [ND];
    logic [1:0]    cnt_d [ND];
    logic [ND-1:0] wr_ptr_q, wr_ptr_d;
    logic [ND-1:0] rd_ptr_q, rd_ptr_d;
    idx_t          rr_q, rr_d;
    idx_t          pend_dst_q, pend_dst_d;
    logic          pend_vld_q, pend_vld_d;
    logic [ND-1:0] grant_q, grant_d;
    logic [1:0]    err_q, err_d;

    logic [ND-1:0] elig_s;
    logic [ND-1:0] vld_s;
    logic [ND-1:0] deq_s;
    logic [DW-1:0] data_s;
    logic          sel_found_s;
    idx_t          sel_idx_s;
    logic          req_any_s, req_one_s, full_s, accept_s;
    idx_t          req_idx_s;

    // A destination is eligible only once its data has landed; the in-flight reservation is excluded.
    always_comb begin
        for (int d = 0; d < ND; d++) begin
            elig_s[d] = (cnt_q[d] != 2'd0) &&
                        !((cnt_q[d] == 2'd1) && pend_vld_q && (pend_dst_q == idx_t'(d)));
        end
    end

    // Round-robin pick of the first eligible destination at or after rr, and the resulting dequeue.
    always_comb begin
        idx_t cand_s;
        cand_s      = '0;
        sel_found_s = 1'b0;
        sel_idx_s   = rr_q;
        for (int i = 0; i < ND; i++) begin
            cand_s = idx_t'((int'(rr_q) + i) % ND);
            if (!sel_found_s && elig_s[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        vld_s = '0;
        if (sel_found_s) begin
            vld_s[sel_idx_s] = 1'b1;
            data_s           = mem_q[sel_idx_s][rd_ptr_q[sel_idx_s]];
        end else begin
            data_s = '0;
        end
        deq_s = vld_s & bus.cpx_out_rdy;
    end

    // Request decode; fullness accounts for a dequeue of the same destination in this cycle.
    always_comb begin
        req_any_s = (bus.io_cpx_req_cq2 != '0);
        req_one_s = is_onehot(bus.io_cpx_req_cq2);
        req_idx_s = onehot_idx(bus.io_cpx_req_cq2);
        full_s    = (cnt_q[req_idx_s] == 2'd2) && !deq_s[req_idx_s];
        accept_s  = req_one_s && !full_s;
    end

    // Next-state for FIFOs, counts, pointers, arbiter, grant and sticky errors.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q ^ deq_s;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        pend_vld_d = accept_s;
        pend_dst_d = accept_s ? req_idx_s : '0;
        grant_d    = deq_s;
        err_d      = err_q | {req_any_s && !req_one_s, req_one_s && full_s};
        if (pend_vld_q) begin
            mem_d[pend_dst_q][wr_ptr_q[pend_dst_q]] = bus.io_cpx_data_ca2;
            wr_ptr_d[pend_dst_q]                    = ~wr_ptr_q[pend_dst_q];
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        for (int d = 0; d < ND; d++) begin
            case ({accept_s && (req_idx_s == idx_t'(d)), deq_s[d]})
                2'b10:   cnt_d[d] = cnt_q[d] + 2'd1;
                2'b01:   cnt_d[d] = cnt_q[d] - 2'd1;
                default: cnt_d[d] = cnt_q[d];
            endcase
        end
        if (deq_s != '0) begin
            rr_d = (sel_idx_s == idx_t'(ND - 1)) ? '0 : sel_idx_s + idx_t'(1);
        end else begin
            rr_d = rr_q;
        end
    end

    // State registers; reset flushes everything including a pending data cycle.
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            for (int d = 0; d < ND; d++) begin
                mem_q[d][0] <= '0;
                mem_q[d][1] <= '0;
                cnt_q[d]    <= 2'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rr_q       <= '0;
            pend_dst_q <= '0;
            pend_vld_q <= 1'b0;
            grant_q    <= '0;
            err_q      <= 2'b00;
        end else begin
            mem_q      <= mem_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rr_q       <= rr_d;
            pend_dst_q <= pend_dst_d;
            pend_vld_q <= pend_vld_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
        end
    end

    assign bus.cpx_out_vld     = vld_s;
    assign bus.cpx_out_data    = data_s;
    assign bus.cpx_io_grant_cx = grant_q;
    assign bus.cpx_io_err      = err_q;
endmodule

// File: tb/tb_cpx_io_rcv_q.sv
// Bench for cpx_io_rcv_q: a cycle table of directed scenarios, then a credit-respecting
// random phase whose expected packets are queued per destination and checked on drain.
module tb_cpx_io_rcv_q;
    localparam int DW = 145;
    localparam int ND = 8;

    logic rclk;
    logic rst_l;
    int   checks;
    int   failures;

    cpx_io_rcv_q_if #(.DW(DW), .ND(ND)) bus ();

    cpx_io_rcv_q #(.DW(DW), .ND(ND)) dut (
        .rclk  (rclk),
        .rst_l (rst_l),
        .bus   (bus.slave)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        logic [ND-1:0] req;
        logic [DW-1:0] data;
        logic [ND-1:0] rdy;
        logic          rst;
        logic [ND-1:0] ev;
        logic [DW-1:0] ed;
        logic [ND-1:0] eg;
        logic [1:0]    ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [ND-1:0] req, input logic [DW-1:0] data, input logic [ND-1:0] rdy,
                       input logic rst, input logic [ND-1:0] ev, input logic [DW-1:0] ed,
                       input logic [ND-1:0] eg, input logic [1:0] ee);
        vec_t v;
        v.req = req; v.data = data; v.rdy = rdy; v.rst = rst;
        v.ev = ev; v.ed = ed; v.eg = eg; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int cyc, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) r = {r[DW-33:0], 32'($urandom)};
        return r;
    endfunction

    logic [DW-1:0] expq [ND][$];
    int            credit [ND];
    logic          pend_v;
    int            pend_d;
    logic [DW-1:0] pend_data;
    logic [ND-1:0] deq_prev;
    logic [ND-1:0] vld;
    int            d;

    initial begin
        checks   = 0;
        failures = 0;
        rst_l    = 1'b0;
        bus.io_cpx_req_cq2  = '0;
        bus.io_cpx_data_ca2 = '0;
        bus.cpx_out_rdy     = '0;

        //   req     data        rdy    rst   vld     data        grant   err
        // single packet to dest 2
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h04, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'h1ABC,  8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h04, 145'h1ABC,  8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h04, 2'b00);
        // dest 2 full, new request in the same cycle as a dequeue
        add(8'h04, 145'h0,     8'h00, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h04, 145'hB1,    8'h00, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'hB2,    8'h00, 1'b1, 8'h04, 145'hB1,    8'h00, 2'b00);
        add(8'h04, 145'h0,     8'h04, 1'b1, 8'h04, 145'hB1,    8'h00, 2'b00);
        add(8'h00, 145'hB3,    8'h00, 1'b1, 8'h04, 145'hB2,    8'h04, 2'b00);
        add(8'h00, 145'h0,     8'h04, 1'b1, 8'h04, 145'hB2,    8'h00, 2'b00);
        add(8'h00, 145'h0,     8'h04, 1'b1, 8'h04, 145'hB3,    8'h04, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h04, 2'b00);
        // dest 5 held under backpressure
        add(8'h20, 145'h0,     8'hDF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'h555,   8'hDF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hDF, 1'b1, 8'h20, 145'h555,   8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hDF, 1'b1, 8'h20, 145'h555,   8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hDF, 1'b1, 8'h20, 145'h555,   8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hDF, 1'b1, 8'h20, 145'h555,   8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h20, 145'h555,   8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h20, 2'b00);
        // dest 7 drains and wraps rr to 0
        add(8'h80, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'h777,   8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h80, 145'h777,   8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h80, 2'b00);
        // round-robin over dests 1, 3, 6
        add(8'h02, 145'h0,     8'h00, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h08, 145'hA1,    8'h00, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h40, 145'hA3,    8'h00, 1'b1, 8'h02, 145'hA1,    8'h00, 2'b00);
        add(8'h00, 145'hA6,    8'h00, 1'b1, 8'h02, 145'hA1,    8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h02, 145'hA1,    8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h08, 145'hA3,    8'h02, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h40, 145'hA6,    8'h08, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h40, 2'b00);
        // overflow: three requests to dest 0 with rdy low
        add(8'h01, 145'h0,     8'h00, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h01, 145'hD1,    8'h00, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h01, 145'hD2,    8'h00, 1'b1, 8'h01, 145'hD1,    8'h00, 2'b00);
        add(8'h00, 145'hD3,    8'h00, 1'b1, 8'h01, 145'hD1,    8'h00, 2'b01);
        add(8'h00, 145'h0,     8'h00, 1'b1, 8'h01, 145'hD1,    8'h00, 2'b01);
        add(8'h00, 145'h0,     8'h01, 1'b1, 8'h01, 145'hD1,    8'h00, 2'b01);
        add(8'h00, 145'h0,     8'h01, 1'b1, 8'h01, 145'hD2,    8'h01, 2'b01);
        add(8'h00, 145'h0,     8'h01, 1'b1, 8'h00, 145'h0,     8'h01, 2'b01);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b01);
        // non-one-hot request
        add(8'h11, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b01);
        add(8'h00, 145'hBAD,   8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b11);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b11);
        // reset pulse with entries queued and a data cycle pending
        add(8'h08, 145'h0,     8'h00, 1'b1, 8'h00, 145'h0,     8'h00, 2'b11);
        add(8'h40, 145'hC1,    8'h00, 1'b1, 8'h00, 145'h0,     8'h00, 2'b11);
        add(8'h02, 145'hC2,    8'h00, 1'b1, 8'h08, 145'hC1,    8'h00, 2'b11);
        add(8'h00, 145'hC3,    8'hFF, 1'b0, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h04, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'hE1,    8'hFF, 1'b1, 8'h00, 145'h0,     8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h04, 145'hE1,    8'h00, 2'b00);
        add(8'h00, 145'h0,     8'hFF, 1'b1, 8'h00, 145'h0,     8'h04, 2'b00);

        repeat (3) @(posedge rclk);
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge rclk);
            #1;
            rst_l               = tbl[k].rst;
            bus.io_cpx_req_cq2  = tbl[k].req;
            bus.io_cpx_data_ca2 = tbl[k].data;
            bus.cpx_out_rdy     = tbl[k].rdy;
            @(negedge rclk);
            chk("vld", k, DW'(bus.cpx_out_vld), DW'(tbl[k].ev));
            if (tbl[k].ev != '0) chk("data", k, bus.cpx_out_data, tbl[k].ed);
            chk("grant", k, DW'(bus.cpx_io_grant_cx), DW'(tbl[k].eg));
            chk("err", k, DW'(bus.cpx_io_err), DW'(tbl[k].ee));
        end

        // Random phase: source obeys 2 credits per destination, returned by grants.
        for (int i = 0; i < ND; i++) credit[i] = 0;
        pend_v   = 1'b0;
        pend_d   = 0;
        pend_data = '0;
        deq_prev = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge rclk);
            #1;
            bus.io_cpx_req_cq2  = '0;
            bus.io_cpx_data_ca2 = rnd();
            if (pend_v) begin
                bus.io_cpx_data_ca2 = pend_data;
                expq[pend_d].push_back(pend_data);
                pend_v = 1'b0;
            end
            if (c < 560 && $urandom_range(0, 3) != 0) begin
                d = int'($urandom_range(0, ND - 1));
                if (credit[d] < 2) begin
                    bus.io_cpx_req_cq2 = ND'(1) << d;
                    credit[d]++;
                    pend_v    = 1'b1;
                    pend_d    = d;
                    pend_data = rnd();
                end
            end
            bus.cpx_out_rdy = (c >= 560) ? {ND{1'b1}} : (ND'($urandom) | ND'($urandom));
            @(negedge rclk);
            chk("rgrant", c, DW'(bus.cpx_io_grant_cx), DW'(deq_prev));
            for (int i = 0; i < ND; i++) if (deq_prev[i]) credit[i]--;
            vld = bus.cpx_out_vld;
            chk("ronehot", c, DW'($countones(vld) > 1), DW'(0));
            if (vld != '0) begin
                d = 0;
                for (int i = 0; i < ND; i++) if (vld[i]) d = i;
                if (expq[d].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rspurious cyc=%0d got=vld %0h exp=no packet", c, vld);
                end else begin
                    chk("rdata", c, bus.cpx_out_data, expq[d][0]);
                    if (bus.cpx_out_rdy[d]) void'(expq[d].pop_front());
                end
            end
            deq_prev = vld & bus.cpx_out_rdy;
        end
        for (int i = 0; i < ND; i++) begin
            chk("rleft", i, DW'(expq[i].size()), DW'(0));
            chk("rcredit", i, DW'(credit[i]), DW'(0));
        end
        chk("rerr", 0, DW'(bus.cpx_io_err), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
